gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl: RTL and testbench

Exhaustive built-in self-test sequencer for one oai221 instance. The sequencer drives all 32 input combinations of A1, A2, B1, B2 and C, waits a programmable settle time, samples ZN, and compares each sample against the golden function ZN = ~((A1|A2) & (B1|B2) & C). It reports pass/fail, a saturating mismatch count and the first failing vector. The block sits beside the cell under test in library characterisation and silicon-debug harnesses.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl.sv | 117 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl.sv
// Exhaustive BIST sequencer for one oai221 cell: walks all 32 input vectors, samples ZN after a
// programmable settle time and accumulates mismatches against ZN = ~((A1|A2) & (B1|B2) & C).
module gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 6
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VLD,
  output logic [4:0]       FAIL_VEC
);

  localparam logic [3:0]       Reload = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [4:0]       vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_vld_q, fail_vld_d;
  logic [4:0]       fail_vec_q, fail_vec_d;
  logic             zn_exp;

  assign zn_exp = ~((vec_q[0] | vec_q[1]) & (vec_q[2] | vec_q[3]) & vec_q[4]);

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    fail_vec_d = fail_vec_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          state_d    = StRun;
          vec_d      = 5'd0;
          cnt_d      = Reload;
          err_d      = '0;
          fail_vld_d = 1'b0;
          fail_vec_d = 5'd0;
        end
      end
      StRun: begin
        // Abort wins over a coincident sample edge, so that sample is never counted.
        if (ABORT) begin
          state_d = StIdle;
          vec_d   = 5'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (ZN != zn_exp) begin
            if (err_q != ErrMax) err_d = err_q + 1'b1;
            if (!fail_vld_q) begin
              fail_vld_d = 1'b1;
              fail_vec_d = vec_q;
            end
          end
          if (vec_q != 5'd31) begin
            vec_d = vec_q + 5'd1;
            cnt_d = Reload;
          end else begin
            state_d = StDone;
            vec_d   = 5'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= StIdle;
      vec_q      <= 5'd0;
      cnt_q      <= 4'd0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_vec_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  // vec_q is forced to zero outside a run, so the stimulus is driven straight from the register.
  assign {C, B2, B1, A2, A1} = vec_q;
  assign BUSY     = (state_q == StRun);
  assign DONE     = (state_q == StDone);
  assign PASS     = DONE && (err_q == '0);
  assign ERR_CNT  = err_q;
  assign FAIL_VLD = fail_vld_q;
  assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl.sv
// Bench for the oai221 BIST sequencer: a default instance and a SETTLE=1/ERR_W=3 instance, each
// fed by a cell model whose response is the golden function XOR a per-vector fault mask.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, abort_a = 1'b0, zn_a;
  logic        a1_a, a2_a, b1_a, b2_a, c_a, busy_a, done_a, pass_a, fvld_a;
  logic [5:0]  err_a;
  logic [4:0]  fvec_a;
  logic        start_b = 1'b0, abort_b = 1'b0, zn_b;
  logic        a1_b, a2_b, b1_b, b2_b, c_b, busy_b, done_b, pass_b, fvld_b;
  logic [2:0]  err_b;
  logic [4:0]  fvec_b;
  logic [31:0] mask_a = '0, mask_b = '0;
  logic [4:0]  vec_a, vec_b;

  int tests_run = 0;
  int failures  = 0;

  function automatic logic golden(input logic [4:0] v);
    return ~((v[0] | v[1]) & (v[2] | v[3]) & v[4]);
  endfunction

  function automatic logic [31:0] stuck_mask(input logic val);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (golden(5'(i)) != val);
    return m;
  endfunction

  function automatic int errs_below(input logic [31:0] m, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(m[i]);
    return c;
  endfunction

  function automatic logic [4:0] first_fail(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  assign vec_a = {c_a, b2_a, b1_a, a2_a, a1_a};
  assign vec_b = {c_b, b2_b, b1_b, a2_b, a1_b};
  assign zn_a  = golden(vec_a) ^ mask_a[vec_a];
  assign zn_b  = golden(vec_b) ^ mask_b[vec_b];

  gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl dut_a (
    .CLK(clk), .RN(rn), .START(start_a), .ABORT(abort_a), .ZN(zn_a),
    .A1(a1_a), .A2(a2_a), .B1(b1_a), .B2(b2_a), .C(c_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a),
    .FAIL_VLD(fvld_a), .FAIL_VEC(fvec_a)
  );

  gf180mcu_fd_sc_mcu7t5v0__oai221_bist_ctrl #(.SETTLE(1), .ERR_W(3)) dut_b (
    .CLK(clk), .RN(rn), .START(start_b), .ABORT(abort_b), .ZN(zn_b),
    .A1(a1_b), .A2(a2_b), .B1(b1_b), .B2(b2_b), .C(c_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b),
    .FAIL_VLD(fvld_b), .FAIL_VEC(fvec_b)
  );

  // Pulse START, then watch at each falling edge until DONE; vector n must be held for `settle` cycles.
  task automatic run_a(input logic [31:0] m, output int busy_cyc, output int stim_bad,
                       output bit timeout);
    int iter = 0;
    mask_a = m; busy_cyc = 0; stim_bad = 0; timeout = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    while (!done_a && !timeout) begin
      if (busy_a) begin
        if (vec_a !== 5'(busy_cyc / 2)) stim_bad++;
        busy_cyc++;
      end
      iter++;
      if (iter > 200) timeout = 1;
      else @(negedge clk);
    end
  endtask

  task automatic run_b(input logic [31:0] m, output int busy_cyc, output int stim_bad,
                       output bit timeout);
    int iter = 0;
    mask_b = m; busy_cyc = 0; stim_bad = 0; timeout = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    while (!done_b && !timeout) begin
      if (busy_b) begin
        if (vec_b !== 5'(busy_cyc)) stim_bad++;
        busy_cyc++;
      end
      iter++;
      if (iter > 200) timeout = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({vec_a, busy_a, done_a, pass_a, fvld_a} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl_a: got %b want 0", {vec_a, busy_a, done_a, pass_a, fvld_a});
    end
    tests_run++;
    if ({err_a, fvec_a} !== 11'd0) begin
      failures++; $display("FAIL reset_cnt_a: got %0d/%0d want 0/0", err_a, fvec_a);
    end
    tests_run++;
    if ({vec_b, busy_b, done_b, pass_b, fvld_b, err_b, fvec_b} !== 17'd0) begin
      failures++;
      $display("FAIL reset_b: got %b want 0", {vec_b, busy_b, done_b, pass_b, fvld_b, err_b, fvec_b});
    end
    repeat (2) @(negedge clk);
    rn = 1'b1;
  endtask

  task automatic test_golden();
    int bc, sb;
    bit to;
    run_a(32'd0, bc, sb, to);
    tests_run++;
    if (to !== 1'b0) begin failures++; $display("FAIL golden_timeout: got %0b want 0", to); end
    tests_run++;
    if (bc != 64) begin failures++; $display("FAIL golden_busy_cycles: got %0d want 64", bc); end
    tests_run++;
    if (sb != 0) begin failures++; $display("FAIL golden_stimulus: got %0d bad cycles want 0", sb); end
    tests_run++;
    if ({done_a, pass_a, busy_a, fvld_a} !== 4'b1100) begin
      failures++; $display("FAIL golden_flags: got %b want 1100", {done_a, pass_a, busy_a, fvld_a});
    end
    tests_run++;
    if ({err_a, vec_a} !== 11'd0) begin
      failures++; $display("FAIL golden_err_vec: got %0d/%0d want 0/0", err_a, vec_a);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (done_a !== 1'b1) begin failures++; $display("FAIL golden_done_hold: got %0b want 1", done_a); end
  endtask

  task automatic test_fault_a(input string name, input logic [31:0] m);
    int bc, sb, exp_err;
    bit to;
    exp_err = sat(errs_below(m, 32), 63);
    run_a(m, bc, sb, to);
    tests_run++;
    if (to || bc != 64) begin
      failures++; $display("FAIL %s_busy: got %0d cycles (timeout %0b) want 64", name, bc, to);
    end
    tests_run++;
    if (err_a !== 6'(exp_err)) begin
      failures++; $display("FAIL %s_err_cnt: got %0d want %0d", name, err_a, exp_err);
    end
    tests_run++;
    if (fvld_a !== (m != 0) || (m != 0 && fvec_a !== first_fail(m))) begin
      failures++;
      $display("FAIL %s_fail_vec: got vld %0b vec %0d want vld %0b vec %0d", name, fvld_a, fvec_a,
               (m != 0), first_fail(m));
    end
    tests_run++;
    if (pass_a !== (m == 0)) begin
      failures++; $display("FAIL %s_pass: got %0b want %0b", name, pass_a, (m == 0));
    end
  endtask

  task automatic test_stuck1();
    test_fault_a("stuck1", stuck_mask(1'b1));
  endtask

  task automatic test_random();
    logic [31:0] m;
    for (int i = 0; i < 6; i++) begin
      m = $urandom() & $urandom();
      if (i == 5) m = $urandom();
      test_fault_a($sformatf("random%0d", i), m);
    end
  endtask

  task automatic test_saturation();
    int bc, sb;
    bit to;
    logic [31:0] m;
    m = stuck_mask(1'b0);
    run_b(m, bc, sb, to);
    tests_run++;
    if (to || bc != 32 || sb != 0) begin
      failures++; $display("FAIL sat_busy: got %0d cycles %0d bad want 32 0", bc, sb);
    end
    tests_run++;
    if (err_b !== 3'(sat(errs_below(m, 32), 7))) begin
      failures++; $display("FAIL sat_err_cnt: got %0d want %0d", err_b, sat(errs_below(m, 32), 7));
    end
    tests_run++;
    if ({fvld_b, fvec_b, pass_b} !== {1'b1, first_fail(m), 1'b0}) begin
      failures++;
      $display("FAIL sat_fail_vec: got %b want %b", {fvld_b, fvec_b, pass_b}, {1'b1, first_fail(m), 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int bc = 0, iter = 0;
    logic [31:0] m;
    m = $urandom() | 32'h0000_0100;
    mask_b = m;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk);
    while (!done_b && iter < 200) begin
      if (busy_b) bc++;
      iter++;
      @(negedge clk);
    end
    tests_run++;
    if (bc != 32 || done_b !== 1'b1) begin
      failures++; $display("FAIL b2b_done: got %0d busy cycles done %0b want 32 1", bc, done_b);
    end
    tests_run++;
    if (err_b !== 3'(sat(errs_below(m, 32), 7))) begin
      failures++; $display("FAIL b2b_err_first: got %0d want %0d", err_b, sat(errs_below(m, 32), 7));
    end
    mask_b = 32'd0;
    @(negedge clk);
    tests_run++;
    if ({done_b, busy_b, err_b, fvld_b, vec_b} !== {1'b0, 1'b1, 3'd0, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL b2b_restart: got done %0b busy %0b err %0d vld %0b vec %0d want 0 1 0 0 0",
               done_b, busy_b, err_b, fvld_b, vec_b);
    end
    start_b = 1'b0;
    iter = 0;
    while (!done_b && iter < 200) begin iter++; @(negedge clk); end
    tests_run++;
    if (pass_b !== 1'b1) begin failures++; $display("FAIL b2b_second_pass: got %0b want 1", pass_b); end
  endtask

  task automatic test_abort();
    int edges[2];
    int n_smp;
    logic [31:0] m;
    edges[0] = 10;
    edges[1] = int'($urandom_range(60, 2));
    m = stuck_mask(1'b0);
    mask_a = m;
    foreach (edges[j]) begin
      n_smp = (edges[j] - 1) / 2;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      repeat (edges[j] - 1) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk); abort_a = 1'b0;
      tests_run++;
      if ({busy_a, done_a, pass_a, vec_a} !== 8'd0) begin
        failures++;
        $display("FAIL abort%0d_flags: got busy %0b done %0b vec %0d want 0 0 0", edges[j], busy_a,
                 done_a, vec_a);
      end
      tests_run++;
      if (err_a !== 6'(errs_below(m, n_smp))) begin
        failures++; $display("FAIL abort%0d_err_cnt: got %0d want %0d", edges[j], err_a,
                             errs_below(m, n_smp));
      end
      tests_run++;
      if (fvld_a !== (errs_below(m, n_smp) != 0)) begin
        failures++; $display("FAIL abort%0d_fail_vld: got %0b", edges[j], fvld_a);
      end
    end
    // START and ABORT together in IDLE: START is taken.
    @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
    tests_run++;
    if ({busy_a, err_a, fvld_a} !== {1'b1, 6'd0, 1'b0}) begin
      failures++; $display("FAIL abort_start_idle: got busy %0b err %0d vld %0b want 1 0 0",
                           busy_a, err_a, fvld_a);
    end
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    tests_run++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_early: got busy %0b want 0", busy_a); end
  endtask

  task automatic test_reset_midrun();
    int bc, sb;
    bit to;
    mask_a = 32'd0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (29) @(negedge clk);
    tests_run++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL midrun_busy: got %0b want 1", busy_a); end
    #2 rn = 1'b0;
    #1;
    tests_run++;
    if ({vec_a, busy_a, done_a, pass_a, fvld_a, err_a, fvec_a} !== 20'd0) begin
      failures++; $display("FAIL midrun_reset: got %b want 0",
                           {vec_a, busy_a, done_a, pass_a, fvld_a, err_a, fvec_a});
    end
    @(negedge clk); rn = 1'b1;
    run_a(32'd0, bc, sb, to);
    tests_run++;
    if (to || bc != 64 || sb != 0 || pass_a !== 1'b1) begin
      failures++; $display("FAIL midrun_rerun: got %0d cycles %0d bad pass %0b want 64 0 1",
                           bc, sb, pass_a);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck1();
    test_random();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
